wb_bus_arbiter: RTL and testbench
=================================

# wb_bus_arbiter

Two-master, one-slave Wishbone B4 arbiter sitting directly downstream of the MIPS core's instruction (ICMU) and data (DCMU) Wishbone master ports. It merges both onto the single system bus toward memory and peripherals. It grants ownership per bus cycle, holds ownership across bursts, and breaks ties round-robin. A watchdog terminates any slave that never answers, returning an error to the stalled master.

## Interface
- `TIMEOUT`, 255: cycles with `s_stb_o` high and no `s_ack_i`/`s_err_i` before the arbiter aborts the access; legal range 1..255.
- `clk` in 1: single system clock; every master and slave signal is synchronous to it.
- `rst` in 1: synchronous, active-high reset.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i` in 1 each: ICMU master cycle, strobe and write enable.
- `m0_addr_i` in 30: word address [31:2].
- `m0_cti_i` in 3: cycle type identifier.
- `m0_bte_i` in 2: burst type extension.
- `m0_sel_i` in 4: byte lane selects.
- `m0_data_i` in 32: ICMU write data.
- `m0_data_o` out 32: read data to ICMU.
- `m0_ack_o`, `m0_err_o` out 1 each: termination signals to ICMU.
- `m1_*`: DCMU master port, identical set of signals with the same widths.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each: cycle, strobe and write enable to the slave.
- `s_addr_o` out 30, `s_cti_o` out 3, `s_bte_o` out 2, `s_sel_o` out 4, `s_data_o` out 32: slave-side request signals.
- `s_data_i` in 32: slave read data.
- `s_ack_i`, `s_err_i` in 1 each: slave termination signals.
- `grant_o` out 2: one-hot current owner; bit0 = m0, bit1 = m1; 2'b00 when idle.
- `timeout_o` out 1: one-cycle pulse when the watchdog fires.

## Operation
- FSM states:
  - IDLE: evaluate requests.
  - GNT0: m0 owns the bus.
  - GNT1: m1 owns the bus.
  - ABORT: watchdog fired; wait for the owner to drop `cyc`.
- IDLE transitions:
  - Only m0 `cyc` high → GNT0.
  - Only m1 `cyc` high → GNT1.
  - Both high → grant the master that was *not* granted last. `last` resets to m0, so the first tie goes to m1.
- GNTx: the owner's request signals pass combinationally to `s_*`. `s_data_i` is routed to both `mX_data_o`. `s_ack_i`/`s_err_i` are routed only to the owner; the other master's ack/err are forced 0.
- Release: owner `cyc` low in GNTx → IDLE at the next edge, and `last` is updated. Ownership never changes while owner `cyc` is high, including a classic cycle with `stb` low and a burst (CTI 010) up to and including its end cycle (CTI 111).
- Watchdog:
  - 8-bit counter increments each cycle that `s_stb_o`=1 and `s_ack_i`=`s_err_i`=0.
  - Clears on ack/err, when `stb` is low, or outside GNTx.
  - Counter reaching `TIMEOUT` → assert owner `mX_err_o` and `timeout_o` for exactly that cycle, then enter ABORT.
- ABORT: all `s_*` forced 0. Owner `cyc` low → IDLE.
- Outside GNTx, all `s_*` outputs are 0.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, `last`=m0.
- Grant latency: master raises `cyc`/`stb` at cycle n → `s_cyc_o`/`s_stb_o` high at n+1.
- Ack path is combinational, zero added latency: `s_ack_i` at cycle k → `mX_ack_o` at cycle k.
- Release takes one IDLE cycle, so there is a minimum of one dead cycle between owners.
- `s_ack_i` and `s_err_i` both high: pass both; the owner treats err as dominant.
- `s_ack_i` arriving in the same cycle the counter hits `TIMEOUT`: the ack wins, the counter clears, and no error or timeout is raised.
- Non-owner raises `cyc` mid-transfer: it waits with ack=0, with no loss of request.
- `rst` mid-transaction: `s_cyc_o` is 0 from the next edge and no ack reaches either master afterward.

## Structure
- Shared package/header `wb_defs`:
  - FSM state encoding.
  - CTI constants: CLASSIC 3'b000, INCR 3'b010, END 3'b111.
  - Grant encoding.
- One sub-module, `wb_watchdog`: the counter plus the `TIMEOUT` compare, producing a `fire` output. Reused later by the peripheral bridge.
- Request muxing and the FSM live in `wb_bus_arbiter`.

## Test plan
- Single request: m0 classic read at addr 0x100; slave acks 2 cycles after `s_stb_o` → `s_cyc_o` one cycle after `m0_cyc_i`, `m0_ack_o` with `m0_data_o`=0xDEADBEEF, `grant_o`=01 then 00.
- Tie: both `cyc` rise together after reset → m1 granted first. After m1 releases, m0 is granted after exactly one IDLE cycle. Next tie → m1.
- Burst hold: m1 4-beat INCR burst (CTI 010,010,010,111) while m0 requests → `grant_o` stays 10 through all 4 acks and `m0_ack_o` stays 0 throughout.
- Watchdog: `TIMEOUT`=8, slave never acks m0 → `m0_err_o` and `timeout_o` pulse on the 8th stalled cycle. `s_*` go to 0, and IDLE follows after `m0_cyc_i` drops.
- Race: ack lands on the 8th stalled cycle → normal ack, no err or timeout.
- Reset mid-burst: `rst` after the second beat → all outputs 0 the next cycle and `grant_o`=00. The first request after reset is granted normally.

Source files
------------

// File: rtl/wb_defs.sv
// Shared definitions for the Wishbone arbiter: FSM states, cycle-type
// codes, grant encodings and the tie-break helper.
package wb_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0   = 2'b01;
    localparam logic [1:0] GNT_M1   = 2'b10;

    // A tie goes to whichever master did not win the previous arbitration.
    function automatic logic pick_m1(
        input logic c0,
        input logic c1,
        input logic last_m1
    );
        return c1 && (!c0 || !last_m1);
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Stall watchdog: counts strobed cycles without a termination and
// flags the cycle on which the count reaches TIMEOUT.
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic stb,
    input  logic ack,
    input  logic err,
    output logic fire
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] count;
    logic       stall;

    assign stall = active & stb & ~ack & ~err;
    assign fire  = stall && (count == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || !stall || fire) begin
            count <= '0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone B4 arbiter with round-robin ties,
// per-cycle ownership and a stall watchdog.
module wb_bus_arbiter
    import wb_defs::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [29:0] m0_addr_i,
    input  logic [2:0]  m0_cti_i,
    input  logic [1:0]  m0_bte_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_data_i,
    output logic [31:0] m0_data_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [29:0] m1_addr_i,
    input  logic [2:0]  m1_cti_i,
    input  logic [1:0]  m1_bte_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_data_i,
    output logic [31:0] m1_data_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [29:0] s_addr_o,
    output logic [2:0]  s_cti_o,
    output logic [1:0]  s_bte_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_data_o,
    input  logic [31:0] s_data_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,

    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    state_t state;
    logic   last_m1;
    logic   own0;
    logic   own1;
    logic   active;
    logic   own_cyc;
    logic   fire;

    assign own0    = (state == ST_GNT0);
    assign own1    = (state == ST_GNT1);
    assign active  = own0 | own1;
    assign own_cyc = own1 ? m1_cyc_i : m0_cyc_i;

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_addr_o = '0;
        s_cti_o  = '0;
        s_bte_o  = '0;
        s_sel_o  = '0;
        s_data_o = '0;
        if (own0) begin
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i;
            s_we_o   = m0_we_i;
            s_addr_o = m0_addr_i;
            s_cti_o  = m0_cti_i;
            s_bte_o  = m0_bte_i;
            s_sel_o  = m0_sel_i;
            s_data_o = m0_data_i;
        end else if (own1) begin
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i;
            s_we_o   = m1_we_i;
            s_addr_o = m1_addr_i;
            s_cti_o  = m1_cti_i;
            s_bte_o  = m1_bte_i;
            s_sel_o  = m1_sel_i;
            s_data_o = m1_data_i;
        end
    end

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .active (active),
        .stb    (s_stb_o),
        .ack    (s_ack_i),
        .err    (s_err_i),
        .fire   (fire)
    );

    assign m0_data_o = active ? s_data_i : '0;
    assign m1_data_o = active ? s_data_i : '0;
    assign m0_ack_o  = own0 & s_ack_i;
    assign m1_ack_o  = own1 & s_ack_i;
    assign m0_err_o  = own0 & (s_err_i | fire);
    assign m1_err_o  = own1 & (s_err_i | fire);
    assign timeout_o = fire;

    always_comb begin
        unique case (state)
            ST_GNT0: grant_o = GNT_M0;
            ST_GNT1: grant_o = GNT_M1;
            default: grant_o = GNT_NONE;
        endcase
    end

    // last_m1 also names the owner while in ABORT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            last_m1 <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (m0_cyc_i | m1_cyc_i) begin
                        if (pick_m1(m0_cyc_i, m1_cyc_i, last_m1)) begin
                            state   <= ST_GNT1;
                            last_m1 <= 1'b1;
                        end else begin
                            state   <= ST_GNT0;
                            last_m1 <= 1'b0;
                        end
                    end
                end
                ST_GNT0, ST_GNT1: begin
                    if (fire) begin
                        state <= ST_ABORT;
                    end else if (!own_cyc) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ABORT: begin
                    if (!(last_m1 ? m1_cyc_i : m0_cyc_i)) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level ownership model.
module tb_wb_bus_arbiter;
    import wb_defs::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [29:0] m0_addr_i;
    logic [2:0]  m0_cti_i;
    logic [1:0]  m0_bte_i;
    logic [3:0]  m0_sel_i;
    logic [31:0] m0_data_i, m0_data_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [29:0] m1_addr_i;
    logic [2:0]  m1_cti_i;
    logic [1:0]  m1_bte_i;
    logic [3:0]  m1_sel_i;
    logic [31:0] m1_data_i, m1_data_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [29:0] s_addr_o;
    logic [2:0]  s_cti_o;
    logic [1:0]  s_bte_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_data_o, s_data_i;
    logic        s_ack_i, s_err_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int vec = 0;
    int bad = 0;

    always #5 clk = ~clk;

    wb_bus_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_addr_i(m0_addr_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
        .m0_sel_i(m0_sel_i), .m0_data_i(m0_data_i), .m0_data_o(m0_data_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_addr_i(m1_addr_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
        .m1_sel_i(m1_sel_i), .m1_data_i(m1_data_i), .m1_data_o(m1_data_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_sel_o(s_sel_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = '0;
        m0_cti_i = CTI_CLASSIC; m0_bte_i = '0; m0_sel_i = '0; m0_data_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = '0;
        m1_cti_i = CTI_CLASSIC; m1_bte_i = '0; m1_sel_i = '0; m1_data_i = '0;
        s_data_i = '0; s_ack_i = 0; s_err_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        next_cycle();
        rst = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        next_cycle();
        next_cycle();
        sample();
        vec++;
        if ({grant_o, s_cyc_o, s_stb_o, s_we_o, timeout_o} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 000000",
                     {grant_o, s_cyc_o, s_stb_o, s_we_o, timeout_o});
        end
        vec++;
        if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_addr_o, m0_data_o}
            !== 66'b0) begin
            bad++;
            $display("FAIL reset_data: got ack/err %b addr %h data %h want 0",
                     {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, s_addr_o, m0_data_o);
        end
        next_cycle();
        rst = 0;
    endtask

    task automatic test_single();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 30'h100; m0_sel_i = 4'hf;
        sample();
        vec++;
        if ({grant_o, s_cyc_o} !== 3'b000) begin
            bad++;
            $display("FAIL single_latency: got %b want 000", {grant_o, s_cyc_o});
        end
        next_cycle();
        sample();
        vec++;
        if ({grant_o, s_cyc_o, s_stb_o} !== 4'b0111 || s_addr_o !== 30'h100) begin
            bad++;
            $display("FAIL single_grant: got %b addr %h want 0111 addr 100",
                     {grant_o, s_cyc_o, s_stb_o}, s_addr_o);
        end
        next_cycle();
        sample();
        vec++;
        if (m0_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL single_wait: got ack %b want 0", m0_ack_o);
        end
        next_cycle();
        s_ack_i = 1; s_data_i = 32'hDEADBEEF;
        sample();
        vec++;
        if ({m0_ack_o, m1_ack_o} !== 2'b10 || m0_data_o !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL single_ack: got acks %b data %h want 10 deadbeef",
                     {m0_ack_o, m1_ack_o}, m0_data_o);
        end
        next_cycle();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        sample();
        vec++;
        if ({grant_o, s_cyc_o} !== 3'b010) begin
            bad++;
            $display("FAIL single_release: got %b want 010", {grant_o, s_cyc_o});
        end
        next_cycle();
        sample();
        vec++;
        if (grant_o !== GNT_NONE) begin
            bad++;
            $display("FAIL single_idle: got %b want 00", grant_o);
        end
    endtask

    task automatic test_tie();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        next_cycle();
        s_ack_i = 1;
        sample();
        vec++;
        if (grant_o !== GNT_M1 || m0_ack_o !== 1'b0) begin
            bad++;
            $display("FAIL tie_first: got grant %b m0_ack %b want 10 0",
                     grant_o, m0_ack_o);
        end
        next_cycle();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        next_cycle();
        sample();
        vec++;
        if ({grant_o, s_cyc_o} !== 3'b000) begin
            bad++;
            $display("FAIL tie_dead_cycle: got %b want 000", {grant_o, s_cyc_o});
        end
        next_cycle();
        sample();
        vec++;
        if (grant_o !== GNT_M0) begin
            bad++;
            $display("FAIL tie_second: got %b want 01", grant_o);
        end
        m0_cyc_i = 0; m0_stb_i = 0;
        next_cycle();
        next_cycle();
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        next_cycle();
        sample();
        vec++;
        if (grant_o !== GNT_M1) begin
            bad++;
            $display("FAIL tie_third: got %b want 10", grant_o);
        end
        clear_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_burst();
        logic [2:0] ctis [4];
        ctis[0] = CTI_INCR; ctis[1] = CTI_INCR;
        ctis[2] = CTI_INCR; ctis[3] = CTI_END;
        do_reset();
        m1_cyc_i = 1; m1_stb_i = 1; m1_cti_i = CTI_INCR; m1_addr_i = 30'h20;
        next_cycle();
        m0_cyc_i = 1; m0_stb_i = 1;
        for (int b = 0; b < 4; b++) begin
            m1_cti_i = ctis[b];
            m1_addr_i = 30'h20 + 30'(b);
            s_ack_i = 1;
            sample();
            vec++;
            if ({grant_o, m1_ack_o, m0_ack_o} !== 4'b1010 || s_cti_o !== ctis[b]
                || s_addr_o !== 30'h20 + 30'(b)) begin
                bad++;
                $display("FAIL burst_beat%0d: got %b cti %b addr %h want 1010 cti %b",
                         b, {grant_o, m1_ack_o, m0_ack_o}, s_cti_o, s_addr_o, ctis[b]);
            end
            next_cycle();
        end
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        next_cycle();
        sample();
        vec++;
        if (grant_o !== GNT_NONE) begin
            bad++;
            $display("FAIL burst_gap: got %b want 00", grant_o);
        end
        next_cycle();
        sample();
        vec++;
        if (grant_o !== GNT_M0) begin
            bad++;
            $display("FAIL burst_handover: got %b want 01", grant_o);
        end
        clear_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_watchdog();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_addr_i = 30'h44;
        next_cycle();
        for (int k = 1; k <= TO; k++) begin
            sample();
            vec++;
            if ({m0_err_o, timeout_o, m1_err_o} !== ((k == TO) ? 3'b110 : 3'b000)) begin
                bad++;
                $display("FAIL wd_stall%0d: got %b want %b", k,
                         {m0_err_o, timeout_o, m1_err_o},
                         (k == TO) ? 3'b110 : 3'b000);
            end
            next_cycle();
        end
        sample();
        vec++;
        if ({s_cyc_o, s_stb_o, s_addr_o, grant_o, m0_err_o, timeout_o} !== 36'b0) begin
            bad++;
            $display("FAIL wd_abort: got cyc %b stb %b addr %h grant %b err %b to %b",
                     s_cyc_o, s_stb_o, s_addr_o, grant_o, m0_err_o, timeout_o);
        end
        next_cycle();
        m0_cyc_i = 0; m0_stb_i = 0;
        next_cycle();
        m1_cyc_i = 1; m1_stb_i = 1;
        next_cycle();
        sample();
        vec++;
        if (grant_o !== GNT_M1) begin
            bad++;
            $display("FAIL wd_recover: got %b want 10", grant_o);
        end
        clear_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_race();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1;
        next_cycle();
        for (int k = 1; k < TO; k++) next_cycle();
        s_ack_i = 1;
        sample();
        vec++;
        if ({m0_ack_o, m0_err_o, timeout_o} !== 3'b100) begin
            bad++;
            $display("FAIL race_ack: got %b want 100", {m0_ack_o, m0_err_o, timeout_o});
        end
        next_cycle();
        s_ack_i = 0;
        for (int k = 1; k < TO; k++) begin
            sample();
            vec++;
            if ({m0_err_o, timeout_o} !== 2'b00) begin
                bad++;
                $display("FAIL race_restart%0d: got %b want 00", k,
                         {m0_err_o, timeout_o});
            end
            next_cycle();
        end
        sample();
        vec++;
        if ({m0_err_o, timeout_o} !== 2'b11) begin
            bad++;
            $display("FAIL race_refire: got %b want 11", {m0_err_o, timeout_o});
        end
        next_cycle();
        clear_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_cyc_i = 1; m0_stb_i = 1; m0_cti_i = CTI_INCR;
        next_cycle();
        s_ack_i = 1;
        next_cycle();
        next_cycle();
        rst = 1;
        next_cycle();
        rst = 0;
        sample();
        vec++;
        if ({grant_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, s_cti_o} !== 9'b0
            || m0_data_o !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid: got %b data %h want 0",
                     {grant_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, s_cti_o},
                     m0_data_o);
        end
        s_ack_i = 0;
        next_cycle();
        sample();
        vec++;
        if ({grant_o, s_cyc_o} !== 3'b011) begin
            bad++;
            $display("FAIL rst_regrant: got %b want 011", {grant_o, s_cyc_o});
        end
        clear_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_random(input int n);
        int          owner, who, last, cnt, o;
        logic [1:0]  mc, ms, ack_seen, err_seen;
        logic [29:0] ma [2];
        logic [1:0]  e_grant, e_ack, e_err;
        logic        e_scyc, e_sstb, e_to, stall, fire;
        logic [29:0] e_addr;
        logic [31:0] e_data;
        do_reset();
        owner = 0; who = 0; last = 0; cnt = 0;
        mc = 0; ms = 0; ack_seen = 0; err_seen = 0;
        ma[0] = '0; ma[1] = '0;
        for (int i = 0; i < n; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (mc[m]) begin
                    if (err_seen[m]) mc[m] = 0;
                    else if (ack_seen[m] && ($urandom % 2 == 0)) mc[m] = 0;
                    else if (ack_seen[m]) ma[m] = 30'($urandom);
                    ms[m] = mc[m] && ($urandom % 8 != 0);
                end else if ($urandom % 3 == 0) begin
                    mc[m] = 1; ms[m] = 1; ma[m] = 30'($urandom);
                end else begin
                    ms[m] = 0;
                end
            end
            m0_cyc_i = mc[0]; m0_stb_i = ms[0]; m0_addr_i = ma[0];
            m1_cyc_i = mc[1]; m1_stb_i = ms[1]; m1_addr_i = ma[1];
            s_ack_i = ($urandom % 5) < 2;
            s_err_i = ($urandom % 20) == 0;
            s_data_i = $urandom;

            e_grant = 0; e_scyc = 0; e_sstb = 0; e_addr = 0; e_data = 0;
            e_ack = 0; e_err = 0; e_to = 0; stall = 0; fire = 0; o = 0;
            if (owner == 1 || owner == 2) begin
                o = owner - 1;
                e_grant[o] = 1;
                e_scyc = mc[o]; e_sstb = ms[o]; e_addr = ma[o]; e_data = s_data_i;
                stall = ms[o] && !s_ack_i && !s_err_i;
                fire = stall && (cnt == TO - 1);
                e_ack[o] = s_ack_i;
                e_err[o] = s_err_i | fire;
                e_to = fire;
            end
            sample();
            vec++;
            if ({grant_o, s_cyc_o, s_stb_o, m1_ack_o, m0_ack_o, m1_err_o, m0_err_o,
                 timeout_o} !== {e_grant, e_scyc, e_sstb, e_ack, e_err, e_to}
                || s_addr_o !== e_addr || m0_data_o !== e_data
                || m1_data_o !== e_data) begin
                bad++;
                $display("FAIL rand_cycle%0d: got %b addr %h data %h want %b addr %h data %h",
                         i, {grant_o, s_cyc_o, s_stb_o, m1_ack_o, m0_ack_o,
                             m1_err_o, m0_err_o, timeout_o},
                         s_addr_o, m0_data_o,
                         {e_grant, e_scyc, e_sstb, e_ack, e_err, e_to}, e_addr, e_data);
            end
            ack_seen = e_ack & ms;
            err_seen = e_err;

            case (owner)
                0: begin
                    if (mc[0] && mc[1]) begin
                        owner = (last == 0) ? 2 : 1;
                        last = 1 - last;
                    end else if (mc[0]) begin
                        owner = 1; last = 0;
                    end else if (mc[1]) begin
                        owner = 2; last = 1;
                    end
                    cnt = 0;
                end
                1, 2: begin
                    cnt = (stall && !fire) ? cnt + 1 : 0;
                    if (fire) begin
                        who = o; owner = 3;
                    end else if (!mc[o]) begin
                        owner = 0;
                    end
                end
                default: begin
                    cnt = 0;
                    if (!mc[who]) owner = 0;
                end
            endcase
            next_cycle();
        end
        clear_inputs();
        next_cycle();
        next_cycle();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_single();
        test_tie();
        test_burst();
        test_watchdog();
        test_race();
        test_reset_mid();
        test_random(1500);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
